udp_gmii_rx: RTL and testbench

UDP_GMII_RX -- requirements
Module: udp_gmii_rx

---
 rtl/udp_gmii_rx.sv | 255 +++++++++++++++++++++++++
 tb/tb_udp_gmii_rx.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_gmii_rx.sv
// udp_gmii_rx: GMII receive path that strips preamble, Ethernet, IPv4 and UDP
// headers of frames addressed to this board and streams the UDP payload out.
// Optional FCS checking is built when the macro UDP_RX_CRC_CHECK_EN is defined.
module udp_gmii_rx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [15:0] UDP_PORT  = 16'd1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_eth_rxdv,
    input  logic [7:0]  gmii_eth_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic [15:0] rx_len,
    output logic [31:0] src_ip,
    output logic [47:0] src_mac,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic        rx_busy
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, DATA, PAD, DROP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] byteCnt_q, byteCnt_d;
    logic [39:0] hdrShift_q, hdrShift_d;
    logic        firstCycle_q;
    logic [7:0]  rxData_q, rxData_d;
    logic        rxValid_q, rxValid_d;
    logic        rxSof_q, rxSof_d;
    logic        rxEof_q, rxEof_d;
    logic [15:0] rxLen_q, rxLen_d;
    logic [31:0] srcIp_q, srcIp_d;
    logic [47:0] srcMac_q, srcMac_d;
    logic        pktOk_q, pktOk_d;
    logic        pktErr_q, pktErr_d;
    logic [47:0] shiftIn;
    logic        crcOk;

    // Header fields are assembled big-endian from the last six bytes seen
    assign shiftIn = {hdrShift_q, gmii_eth_rxd};

`ifdef UDP_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d;
    logic [31:0] dly_q, dly_d;
    logic [2:0]  fill_q, fill_d;
    logic [31:0] fcs;
    logic        sfdSeen;
    logic        feedByte;

    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign sfdSeen  = gmii_eth_rxdv && (state_q == PREAMBLE) &&
                      (gmii_eth_rxd == 8'hD5) && (byteCnt_q == 16'd6);
    assign feedByte = gmii_eth_rxdv &&
                      (state_q inside {ETH_HEAD, IP_HEAD, UDP_HEAD, DATA, PAD});
    assign fcs      = ~crc_q;
    assign crcOk    = (fill_q == 3'd4) &&
                      (dly_q == {fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24]});

    // The last four bytes are held back so the FCS itself never enters the CRC
    always_comb begin
        crc_d  = crc_q;
        dly_d  = dly_q;
        fill_d = fill_q;
        if (sfdSeen) begin
            crc_d  = 32'hFFFF_FFFF;
            fill_d = 3'd0;
        end else if (feedByte) begin
            dly_d = {dly_q[23:0], gmii_eth_rxd};
            if (fill_q == 3'd4) begin
                crc_d = crcByte(crc_q, dly_q[31:24]);
            end else begin
                fill_d = fill_q + 3'd1;
            end
        end
    end

    // CRC accumulator and delay line registers
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q  <= 32'hFFFF_FFFF;
            dly_q  <= 32'h0;
            fill_q <= 3'd0;
        end else begin
            crc_q  <= crc_d;
            dly_q  <= dly_d;
            fill_q <= fill_d;
        end
    end
`else
    assign crcOk = 1'b1;
`endif

    // Frame parser: next state, header checks and payload output generation
    always_comb begin
        state_d    = state_q;
        hdrShift_d = gmii_eth_rxdv ? shiftIn[39:0] : hdrShift_q;
        rxData_d   = rxData_q;
        rxValid_d  = 1'b0;
        rxSof_d    = 1'b0;
        rxEof_d    = 1'b0;
        rxLen_d    = rxLen_q;
        srcIp_d    = srcIp_q;
        srcMac_d   = srcMac_q;
        pktOk_d    = 1'b0;
        pktErr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gmii_eth_rxdv) begin
                    state_d = (firstCycle_q || gmii_eth_rxd != 8'h55) ? DROP : PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (!gmii_eth_rxdv) begin
                    state_d = IDLE;
                end else if (gmii_eth_rxd == 8'h55 && byteCnt_q < 16'd6) begin
                    state_d = PREAMBLE;
                end else if (gmii_eth_rxd == 8'hD5 && byteCnt_q == 16'd6) begin
                    state_d = ETH_HEAD;
                end else begin
                    state_d = DROP;
                end
            end
            ETH_HEAD: begin
                if (!gmii_eth_rxdv) begin
                    state_d = IDLE;
                end else begin
                    case (byteCnt_q)
                        16'd5:  if (shiftIn != BOARD_MAC && shiftIn != 48'hFFFF_FFFF_FFFF) state_d = DROP;
                        16'd11: srcMac_d = shiftIn;
                        16'd12: if (gmii_eth_rxd != 8'h08) state_d = DROP;
                        16'd13: state_d = (gmii_eth_rxd == 8'h00) ? IP_HEAD : DROP;
                        default: ;
                    endcase
                end
            end
            IP_HEAD: begin
                if (!gmii_eth_rxdv) begin
                    state_d = IDLE;
                end else begin
                    case (byteCnt_q)
                        16'd0:  if (gmii_eth_rxd != 8'h45) state_d = DROP;
                        16'd9:  if (gmii_eth_rxd != 8'd17) state_d = DROP;
                        16'd15: srcIp_d = shiftIn[31:0];
                        16'd19: state_d = (shiftIn[31:0] == BOARD_IP) ? UDP_HEAD : DROP;
                        default: ;
                    endcase
                end
            end
            UDP_HEAD: begin
                if (!gmii_eth_rxdv) begin
                    state_d = IDLE;
                end else begin
                    case (byteCnt_q)
                        16'd3: if (shiftIn[15:0] != UDP_PORT) state_d = DROP;
                        16'd5: begin
                            if (shiftIn[15:0] < 16'd9) state_d = DROP;
                            else rxLen_d = shiftIn[15:0] - 16'd8;
                        end
                        16'd7: state_d = DATA;
                        default: ;
                    endcase
                end
            end
            DATA: begin
                if (!gmii_eth_rxdv) begin
                    pktErr_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    rxValid_d = 1'b1;
                    rxData_d  = gmii_eth_rxd;
                    rxSof_d   = (byteCnt_q == 16'd0);
                    if (byteCnt_q == rxLen_q - 16'd1) begin
                        rxEof_d = 1'b1;
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                if (!gmii_eth_rxdv) begin
                    pktOk_d  = crcOk;
                    pktErr_d = !crcOk;
                    state_d  = IDLE;
                end
            end
            DROP: begin
                if (!gmii_eth_rxdv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            byteCnt_d = 16'd0;
        end else begin
            byteCnt_d = gmii_eth_rxdv ? byteCnt_q + 16'd1 : byteCnt_q;
        end
    end

    // State and output registers; firstCycle_q blocks locking onto a frame already in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            byteCnt_q    <= 16'd0;
            hdrShift_q   <= 40'h0;
            firstCycle_q <= 1'b1;
            rxData_q     <= 8'h0;
            rxValid_q    <= 1'b0;
            rxSof_q      <= 1'b0;
            rxEof_q      <= 1'b0;
            rxLen_q      <= 16'h0;
            srcIp_q      <= 32'h0;
            srcMac_q     <= 48'h0;
            pktOk_q      <= 1'b0;
            pktErr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            byteCnt_q    <= byteCnt_d;
            hdrShift_q   <= hdrShift_d;
            firstCycle_q <= 1'b0;
            rxData_q     <= rxData_d;
            rxValid_q    <= rxValid_d;
            rxSof_q      <= rxSof_d;
            rxEof_q      <= rxEof_d;
            rxLen_q      <= rxLen_d;
            srcIp_q      <= srcIp_d;
            srcMac_q     <= srcMac_d;
            pktOk_q      <= pktOk_d;
            pktErr_q     <= pktErr_d;
        end
    end

    assign rx_data  = rxData_q;
    assign rx_valid = rxValid_q;
    assign rx_sof   = rxSof_q;
    assign rx_eof   = rxEof_q;
    assign rx_len   = rxLen_q;
    assign src_ip   = srcIp_q;
    assign src_mac  = srcMac_q;
    assign pkt_ok   = pktOk_q;
    assign pkt_err  = pktErr_q;
    assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_udp_gmii_rx.sv
// tb_udp_gmii_rx: randomized frames checked against a byte-level reference model.
module tb_udp_gmii_rx;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10};
    localparam logic [15:0] UDP_PORT  = 16'd1234;

    logic        clk = 1'b0;
    logic        rst;
    logic        gmii_eth_rxdv;
    logic [7:0]  gmii_eth_rxd;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof;
    logic [15:0] rx_len;
    logic [31:0] src_ip;
    logic [47:0] src_mac;
    logic        pkt_ok, pkt_err, rx_busy;

    udp_gmii_rx #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP), .UDP_PORT(UDP_PORT)) dut (
        .clk(clk), .rst(rst), .gmii_eth_rxdv(gmii_eth_rxdv), .gmii_eth_rxd(gmii_eth_rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_len(rx_len), .src_ip(src_ip), .src_mac(src_mac), .pkt_ok(pkt_ok),
        .pkt_err(pkt_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int errorCount = 0;
    int checkCount = 0;

    logic [7:0]  frameQ[$];
    logic [7:0]  gotQ[$];
    logic [7:0]  expPayload[$];
    int          sofCnt, eofCnt, sofIdx, eofIdx, okCnt, errCnt, okEarly;
    logic [15:0] lenAtSof;
    bit          frameActive;

    bit          expAccept, expComplete, expOk, expErr;
    int          expLen;
    logic [31:0] expSrcIp;
    logic [47:0] expSrcMac;

    logic [5:0]  rstSnapFlags;
    logic [15:0] rstSnapLen;
    logic [31:0] rstSnapIp;
    logic [47:0] rstSnapMac;
    logic [7:0]  rstSnapData;
    logic        busySnap;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_sof) begin
                sofCnt++;
                sofIdx   = gotQ.size();
                lenAtSof = rx_len;
            end
            if (rx_eof) begin
                eofCnt++;
                eofIdx = gotQ.size();
            end
            gotQ.push_back(rx_data);
        end
        if (pkt_ok) begin
            okCnt++;
            if (frameActive) okEarly++;
        end
        if (pkt_err) errCnt++;
    end

    task automatic clearMonitor();
        gotQ.delete();
        sofCnt = 0; eofCnt = 0; sofIdx = -1; eofIdx = -1;
        okCnt = 0; errCnt = 0; okEarly = 0; lenAtSof = 16'h0;
    endtask

    function automatic logic [31:0] ethCrc(input logic [7:0] q[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ q[i][k];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic logic [63:0] field(input int pos, input int nb);
        logic [63:0] v;
        v = 64'h0;
        for (int i = 0; i < nb; i++) v = {v[55:0], frameQ[pos + i]};
        return v;
    endfunction

    task automatic pushBytes(inout logic [7:0] q[$], input logic [63:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) q.push_back(v[8*i +: 8]);
    endtask

    task automatic buildFrame(input logic [47:0] dmac, input logic [15:0] etype,
                              input logic [7:0] ver, input logic [7:0] proto,
                              input logic [31:0] dip, input logic [15:0] dport,
                              input int plen, input int padTo, input int pre55,
                              input bit badFcs, input int truncAt);
        logic [7:0]  body[$];
        logic [63:0] r;
        logic [31:0] fcs;
        frameQ.delete();
        for (int i = 0; i < pre55; i++) frameQ.push_back(8'h55);
        frameQ.push_back(8'hD5);
        r = {$urandom, $urandom};
        pushBytes(body, {16'h0, dmac}, 6);
        pushBytes(body, {16'h0, r[47:0]}, 6);
        pushBytes(body, {48'h0, etype}, 2);
        body.push_back(ver);
        body.push_back(8'h00);
        pushBytes(body, 64'(28 + plen), 2);
        pushBytes(body, {32'h0, $urandom}, 4);
        body.push_back(8'd64);
        body.push_back(proto);
        pushBytes(body, {32'h0, $urandom}, 2);
        pushBytes(body, {32'h0, $urandom}, 4);
        pushBytes(body, {32'h0, dip}, 4);
        pushBytes(body, {32'h0, $urandom}, 2);
        pushBytes(body, {48'h0, dport}, 2);
        pushBytes(body, 64'(plen + 8), 2);
        pushBytes(body, {32'h0, $urandom}, 2);
        for (int i = 0; i < plen; i++) body.push_back(8'($urandom_range(0, 255)));
        while (body.size() < padTo) body.push_back(8'h00);
        fcs = ethCrc(body);
        if (badFcs) fcs = fcs ^ (32'h1 << $urandom_range(0, 31));
        for (int k = 0; k < 4; k++) body.push_back(fcs[8*k +: 8]);
        if (truncAt >= 0) begin
            while (body.size() > 42 + truncAt) void'(body.pop_back());
        end
        foreach (body[i]) frameQ.push_back(body[i]);
    endtask

    // Reference model: decides acceptance and expected payload from the raw frame bytes
    task automatic modelFrame();
        int          n;
        int          avail;
        bit          pre;
        logic [63:0] v;
        logic [7:0]  body[$];
        logic [31:0] fcsRx;
        n = frameQ.size();
        expAccept = 0; expComplete = 0; expOk = 0; expErr = 0; expLen = 0;
        expPayload.delete();
        if (n >= 50) begin
            pre = 1;
            for (int i = 0; i < 7; i++) if (frameQ[i] != 8'h55) pre = 0;
            if (frameQ[7] != 8'hD5) pre = 0;
            expAccept = pre && (field(8, 6) == {16'h0, BOARD_MAC} || field(8, 6) == 64'hFFFF_FFFF_FFFF)
                        && field(20, 2) == 64'h0800 && frameQ[22] == 8'h45 && frameQ[31] == 8'd17
                        && field(38, 4) == {32'h0, BOARD_IP} && field(44, 2) == {48'h0, UDP_PORT}
                        && field(46, 2) >= 64'd9;
        end
        if (expAccept) begin
            expLen = int'(field(46, 2)) - 8;
            avail  = n - 50;
            for (int i = 0; i < expLen && i < avail; i++) expPayload.push_back(frameQ[50 + i]);
            expComplete = (expPayload.size() == expLen);
            v = field(14, 6); expSrcMac = v[47:0];
            v = field(34, 4); expSrcIp  = v[31:0];
`ifdef UDP_RX_CRC_CHECK_EN
            if (expComplete) begin
                for (int i = 8; i < n - 4; i++) body.push_back(frameQ[i]);
                fcsRx = {frameQ[n-1], frameQ[n-2], frameQ[n-3], frameQ[n-4]};
                expOk = (ethCrc(body) == fcsRx);
            end
`else
            body.delete();
            fcsRx = 32'h0;
            expOk = expComplete;
`endif
            expErr = !expOk;
        end
    endtask

    task automatic applyStimulus(input int gap, input int rstAt);
        for (int i = 0; i < frameQ.size(); i++) begin
            @(posedge clk); #1;
            if (rstAt >= 0 && i == rstAt + 1) begin
                rstSnapFlags = {rx_valid, rx_sof, rx_eof, pkt_ok, pkt_err, rx_busy};
                rstSnapLen = rx_len; rstSnapIp = src_ip; rstSnapMac = src_mac; rstSnapData = rx_data;
                clearMonitor();
            end
            if (rstAt >= 0 && i == rstAt + 6) busySnap = rx_busy;
            gmii_eth_rxdv = 1'b1;
            gmii_eth_rxd  = frameQ[i];
            frameActive   = 1'b1;
            if (rstAt >= 0 && i == rstAt) rst = 1'b1;
            if (rstAt >= 0 && i == rstAt + 2) rst = 1'b0;
        end
        @(posedge clk); #1;
        gmii_eth_rxdv = 1'b0;
        gmii_eth_rxd  = 8'h00;
        frameActive   = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic checkFrame(input string tag);
        int mm;
        mm = 0;
        for (int i = 0; i < gotQ.size() && i < expPayload.size(); i++) if (gotQ[i] !== expPayload[i]) mm++;
        checkOutput({tag, "_count"}, gotQ.size(), expPayload.size());
        checkOutput({tag, "_data"}, mm, 0);
        checkOutput({tag, "_sof"}, sofCnt, (expPayload.size() > 0) ? 1 : 0);
        checkOutput({tag, "_eof"}, eofCnt, expComplete ? 1 : 0);
        checkOutput({tag, "_ok"}, okCnt, expOk ? 1 : 0);
        checkOutput({tag, "_err"}, errCnt, expErr ? 1 : 0);
        checkOutput({tag, "_okEarly"}, okEarly, 0);
        checkOutput({tag, "_busyAfter"}, rx_busy, 0);
        if (sofCnt == 1 && expPayload.size() > 0) begin
            checkOutput({tag, "_sofIdx"}, sofIdx, 0);
            checkOutput({tag, "_len"}, lenAtSof, expLen);
        end
        if (eofCnt == 1 && expComplete) checkOutput({tag, "_eofIdx"}, eofIdx, expLen - 1);
        if (expAccept) begin
            checkOutput({tag, "_srcMac"}, src_mac, expSrcMac);
            checkOutput({tag, "_srcIp"}, src_ip, expSrcIp);
        end
    endtask

    task automatic runFrame(input string tag);
        modelFrame();
        clearMonitor();
        applyStimulus(3, -1);
        checkFrame(tag);
    endtask

    initial begin
        logic [47:0] dmac;
        logic [15:0] etype, dport;
        logic [7:0]  proto;
        logic [31:0] dip;
        int          plen, padTo, pre55, truncAt, kind, totCount, totOk, totComplete, mm;
        bit          badFcs;
        logic [7:0]  totExp[$];

        rst = 1'b1; gmii_eth_rxdv = 1'b0; gmii_eth_rxd = 8'h00; frameActive = 1'b0;
        clearMonitor();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_flags", {rx_valid, rx_sof, rx_eof, pkt_ok, pkt_err, rx_busy}, 6'b0);
        checkOutput("reset_len", rx_len, 0);
        checkOutput("reset_srcIp", src_ip, 0);
        checkOutput("reset_srcMac", src_mac, 0);
        checkOutput("reset_data", rx_data, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        buildFrame(BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, UDP_PORT, 1036, 0, 7, 0, -1);
        runFrame("full1036");
        checkOutput("full1036_fixedCount", gotQ.size(), 1036);
        checkOutput("full1036_fixedLen", lenAtSof, 1036);

        buildFrame(BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, 16'd1235, 1036, 0, 7, 0, -1);
        runFrame("wrongPort");

        buildFrame(BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, UDP_PORT, 4, 60, 7, 0, -1);
        runFrame("padded4");
        checkOutput("padded4_fixedEofIdx", eofIdx, 3);

        buildFrame(BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, UDP_PORT, 1036, 0, 7, 1, -1);
        runFrame("badFcs");

        buildFrame(BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, UDP_PORT, 1036, 0, 7, 0, 100);
        runFrame("trunc100");
        checkOutput("trunc100_fixedCount", gotQ.size(), 100);

        buildFrame(BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, UDP_PORT, 200, 0, 7, 0, -1);
        clearMonitor();
        busySnap = 1'b0;
        applyStimulus(3, 80);
        checkOutput("midRst_flags", rstSnapFlags, 6'b0);
        checkOutput("midRst_len", rstSnapLen, 0);
        checkOutput("midRst_srcIp", rstSnapIp, 0);
        checkOutput("midRst_srcMac", rstSnapMac, 0);
        checkOutput("midRst_data", rstSnapData, 0);
        checkOutput("midRst_dropBusy", busySnap, 1);
        checkOutput("midRst_count", gotQ.size(), 0);
        checkOutput("midRst_pkts", okCnt + errCnt, 0);
        buildFrame(BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, UDP_PORT, 64, 0, 7, 0, -1);
        runFrame("afterRst");

        for (int f = 0; f < 24; f++) begin
            dmac = BOARD_MAC; etype = 16'h0800; proto = 8'd17; dip = BOARD_IP; dport = UDP_PORT;
            plen = $urandom_range(1, 120); padTo = ($urandom_range(0, 1) == 1) ? 60 : 0;
            pre55 = 7; badFcs = 0; truncAt = -1;
            kind = $urandom_range(0, 10);
            case (kind)
                1: dmac = 48'hFFFF_FFFF_FFFF;
                2: dmac = BOARD_MAC ^ (48'h1 << $urandom_range(0, 47));
                3: etype = 16'h0806;
                4: proto = 8'd6;
                5: dip = BOARD_IP ^ (32'h1 << $urandom_range(0, 31));
                6: dport = UDP_PORT + 16'($urandom_range(1, 100));
                7: plen = 0;
                8: truncAt = $urandom_range(0, plen - 1);
                9: pre55 = ($urandom_range(0, 1) == 1) ? 8 : 6;
                10: badFcs = 1;
                default: ;
            endcase
            buildFrame(dmac, etype, 8'h45, proto, dip, dport, plen, padTo, pre55, badFcs, truncAt);
            runFrame($sformatf("rnd%0d_k%0d", f, kind));
        end

        clearMonitor();
        totExp.delete(); totCount = 0; totOk = 0; totComplete = 0;
        for (int f = 0; f < 3; f++) begin
            buildFrame(BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, UDP_PORT,
                       $urandom_range(1, 80), 60, 7, 0, -1);
            modelFrame();
            foreach (expPayload[i]) totExp.push_back(expPayload[i]);
            totOk += expOk ? 1 : 0;
            totComplete += expComplete ? 1 : 0;
            applyStimulus((f == 2) ? 3 : 0, -1);
        end
        mm = 0;
        for (int i = 0; i < gotQ.size() && i < totExp.size(); i++) if (gotQ[i] !== totExp[i]) mm++;
        checkOutput("b2b_count", gotQ.size(), totExp.size());
        checkOutput("b2b_data", mm, 0);
        checkOutput("b2b_sof", sofCnt, 3);
        checkOutput("b2b_eof", eofCnt, totComplete);
        checkOutput("b2b_ok", okCnt, totOk);
        checkOutput("b2b_err", errCnt, 3 - totOk);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
